// File: rtl/vn_eject_if.sv
// vn_eject_if: bundle between the VN ejection units / tile sink and the
// ejection arbiter. The arbiter uses the slave view; the environment drives
// through the master view.
interface vn_eject_if #(
  parameter int NUM_VN = 3,
  parameter int MSG_W  = 576
);
  logic [NUM_VN-1:0]       req_i;
  logic [NUM_VN*MSG_W-1:0] msg_i;
  logic                    sink_ready_i;
  logic                    msg_valid_o;
  logic [MSG_W-1:0]        msg_o;
  logic [NUM_VN-1:0]       grant_o;
  logic [NUM_VN-1:0]       ack_o;
  logic [NUM_VN-1:0]       starve_o;
  logic                    proto_err_o;
  logic [31:0]             delivered_cnt_o;

  modport slave (
    input  req_i, msg_i, sink_ready_i,
    output msg_valid_o, msg_o, grant_o, ack_o, starve_o, proto_err_o, delivered_cnt_o
  );

  modport master (
    output req_i, msg_i, sink_ready_i,
    input  msg_valid_o, msg_o, grant_o, ack_o, starve_o, proto_err_o, delivered_cnt_o
  );
endinterface

// File: rtl/vn_eject_arbiter.sv
// vn_eject_arbiter: round-robin arbiter sharing one NI sink port among
// NUM_VN virtual-network ejection units. One message in flight at a time:
// IDLE -> GRANT -> ACK -> RELEASE -> IDLE. Also tracks per-VN wait time
// (starvation) and counts delivered messages.
module vn_eject_arbiter #(
  parameter int NUM_VN       = 3,
  parameter int MSG_W        = 576,
  parameter int STARVE_LIMIT = 64,
  parameter int WAIT_CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst,
  vn_eject_if.slave bus
);

  localparam int               IDX_W   = $clog2(NUM_VN);
  localparam logic [IDX_W-1:0] LAST_VN = IDX_W'(NUM_VN - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK, S_RELEASE} state_t;

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   rr_q, rr_d;
  logic [IDX_W-1:0]                   g_q, g_d;
  logic [NUM_VN-1:0]                  grant_q, grant_d;
  logic [NUM_VN-1:0]                  ack_q, ack_d;
  logic                               perr_q, perr_d;
  logic [31:0]                        cnt_q, cnt_d;
  logic [NUM_VN-1:0][WAIT_CNT_W-1:0]  wait_q, wait_d;

  logic                               pick_vld;
  logic [IDX_W-1:0]                   pick_idx;
  int                                 scan;
  logic                               msg_valid;
  logic [NUM_VN-1:0]                  starve;

  // Round-robin pick: first requester found scanning upward from rr_q, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    for (int k = 0; k < NUM_VN; k++) begin
      scan = (int'(rr_q) + k) % NUM_VN;
      if (!pick_vld && bus.req_i[scan]) begin
        pick_vld = 1'b1;
        pick_idx = scan[IDX_W-1:0];
      end
    end
  end

  // Next-state logic for the grant FSM, pointer, counter and error flag.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    grant_d = grant_q;
    ack_d   = '0;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          g_d     = pick_idx;
          grant_d = NUM_VN'(1) << pick_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A dropped request means the slot content is gone: abort without
        // advancing the pointer, even if the sink happens to be ready.
        if (!bus.req_i[g_q]) begin
          perr_d  = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else if (bus.sink_ready_i) begin
          cnt_d   = cnt_q + 32'd1;
          rr_d    = (g_q == LAST_VN) ? '0 : g_q + 1'b1;
          ack_d   = grant_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // Hold ownership until the VN has dropped req for the consumed slot,
        // so the same message is never re-arbitrated.
        if (!bus.req_i[g_q]) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-VN saturating wait counters; cleared while idle-requesting is not true.
  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < NUM_VN; i++) begin
      if (!bus.req_i[i] || grant_q[i]) wait_d[i] = '0;
      else if (&wait_q[i])             wait_d[i] = wait_q[i];
      else                             wait_d[i] = wait_q[i] + 1'b1;
    end
  end

  // Starvation flags straight off the wait counters.
  always_comb begin
    starve = '0;
    for (int i = 0; i < NUM_VN; i++) begin
      starve[i] = (32'(wait_q[i]) >= 32'(STARVE_LIMIT));
    end
  end

  // State register; synchronous reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign msg_valid           = (state_q == S_GRANT);
  assign bus.msg_valid_o     = msg_valid;
  assign bus.msg_o           = msg_valid ? bus.msg_i[int'(g_q)*MSG_W +: MSG_W] : '0;
  assign bus.grant_o         = grant_q;
  assign bus.ack_o           = ack_q;
  assign bus.starve_o        = starve;
  assign bus.proto_err_o     = perr_q;
  assign bus.delivered_cnt_o = cnt_q;

endmodule

// File: tb/tb_vn_eject_arbiter.sv
// tb_vn_eject_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the arbiter.
module tb_vn_eject_arbiter;
  localparam int N    = 3;
  localparam int MW   = 64;
  localparam int SL   = 4;
  localparam int WW   = 3;
  localparam int WMAX = (1 << WW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  vn_eject_if #(.NUM_VN(N), .MSG_W(MW)) bus ();

  vn_eject_arbiter #(.NUM_VN(N), .MSG_W(MW), .STARVE_LIMIT(SL), .WAIT_CNT_W(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [N-1:0] m_grant, m_ack;
  bit           m_done, m_perr;
  int           m_rr;
  logic [31:0]  m_cnt;
  int           m_wait [N];

  function automatic logic [MW-1:0] rnd_msg();
    return {$urandom, $urandom};
  endfunction

  task automatic set_msg(input int i, input logic [MW-1:0] m);
    bus.msg_i[i*MW +: MW] = m;
  endtask

  function automatic logic [MW-1:0] slot(input int i);
    return bus.msg_i[i*MW +: MW];
  endfunction

  function automatic int owner(input logic [N-1:0] g);
    int o = 0;
    for (int i = 0; i < N; i++) if (g[i]) o = i;
    return o;
  endfunction

  task automatic model_reset();
    m_grant = '0; m_ack = '0; m_done = 0; m_perr = 0; m_rr = 0; m_cnt = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  // Advance the model by one clock using the inputs just driven.
  task automatic model_step();
    int own;
    logic [N-1:0] was_ack;
    own = owner(m_grant);
    for (int i = 0; i < N; i++) begin
      if (!bus.req_i[i] || m_grant[i]) m_wait[i] = 0;
      else if (m_wait[i] < WMAX)       m_wait[i] = m_wait[i] + 1;
    end
    was_ack = m_ack;
    m_ack   = '0;
    if (m_grant == '0) begin
      for (int k = 0; k < N; k++)
        if (m_grant == '0 && bus.req_i[(m_rr + k) % N]) m_grant[(m_rr + k) % N] = 1'b1;
    end else if (!m_done) begin
      if (!bus.req_i[own]) begin
        m_perr = 1; m_grant = '0;
      end else if (bus.sink_ready_i) begin
        m_cnt = m_cnt + 1; m_rr = (own + 1) % N; m_done = 1; m_ack = m_grant;
      end
    end else if (was_ack == '0 && !bus.req_i[own]) begin
      m_grant = '0; m_done = 0;
    end
  endtask

  // Called at a negedge; leaves the DUT out of reset at a negedge.
  task automatic apply_reset();
    rst = 1'b1; bus.req_i = '0; bus.sink_ready_i = 1'b0; bus.msg_i = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.req_i = '1; bus.sink_ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_msg(i, rnd_msg());
    @(negedge clk); @(negedge clk);
    n_tests++; if (bus.grant_o !== '0) begin n_fail++; $display("FAIL reset_grant: got %b exp 000", bus.grant_o); end
    n_tests++; if (bus.ack_o !== '0) begin n_fail++; $display("FAIL reset_ack: got %b exp 000", bus.ack_o); end
    n_tests++; if (bus.msg_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.msg_valid_o); end
    n_tests++; if (bus.msg_o !== '0) begin n_fail++; $display("FAIL reset_msg: got %h exp 0", bus.msg_o); end
    n_tests++; if (bus.starve_o !== '0) begin n_fail++; $display("FAIL reset_starve: got %b exp 000", bus.starve_o); end
    n_tests++; if (bus.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b exp 0", bus.proto_err_o); end
    n_tests++; if (bus.delivered_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d exp 0", bus.delivered_cnt_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic test_single();
    logic [MW-1:0] m;
    apply_reset();
    m = rnd_msg(); set_msg(1, m); set_msg(0, rnd_msg()); set_msg(2, rnd_msg());
    bus.req_i = 3'b010; bus.sink_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b010) begin n_fail++; $display("FAIL single_grant: got %b exp 010", bus.grant_o); end
    n_tests++; if (bus.msg_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", bus.msg_valid_o); end
    n_tests++; if (bus.msg_o !== m) begin n_fail++; $display("FAIL single_msg: got %h exp %h", bus.msg_o, m); end
    n_tests++; if (bus.ack_o !== 3'b000) begin n_fail++; $display("FAIL single_early_ack: got %b exp 000", bus.ack_o); end
    @(negedge clk);
    n_tests++; if (bus.ack_o !== 3'b010) begin n_fail++; $display("FAIL single_ack: got %b exp 010", bus.ack_o); end
    n_tests++; if (bus.delivered_cnt_o !== 32'd1) begin n_fail++; $display("FAIL single_cnt: got %0d exp 1", bus.delivered_cnt_o); end
    n_tests++; if (bus.msg_o !== '0) begin n_fail++; $display("FAIL single_msg_gated: got %h exp 0", bus.msg_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ack_o !== 3'b000 || bus.grant_o !== 3'b010) begin n_fail++; $display("FAIL single_release: got ack %b grant %b exp ack 000 grant 010", bus.ack_o, bus.grant_o); end
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b000) begin n_fail++; $display("FAIL single_idle: got %b exp 000", bus.grant_o); end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] m;
    apply_reset();
    m = rnd_msg(); set_msg(0, m); set_msg(1, rnd_msg());
    bus.req_i = 3'b001; bus.sink_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.msg_valid_o !== 1'b1 || bus.msg_o !== m || bus.ack_o !== 3'b000) begin
        n_fail++; $display("FAIL bp_hold cycle %0d: got valid %b msg %h ack %b exp valid 1 msg %h ack 000", k, bus.msg_valid_o, bus.msg_o, bus.ack_o, m);
      end
      set_msg(1, rnd_msg());  // other slot churns; output must not follow it
    end
    bus.sink_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ack_o !== 3'b001) begin n_fail++; $display("FAIL bp_ack: got %b exp 001", bus.ack_o); end
    n_tests++; if (bus.delivered_cnt_o !== 32'd1) begin n_fail++; $display("FAIL bp_cnt: got %0d exp 1", bus.delivered_cnt_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_order [4];
    logic [N-1:0] got_order [4];
    logic [N-1:0] prev;
    int ngr;
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    apply_reset();
    for (int i = 0; i < N; i++) set_msg(i, rnd_msg());
    bus.req_i = '1; bus.sink_ready_i = 1'b1;
    ngr = 0; prev = '0;
    for (int cyc = 0; cyc < 60 && ngr < 4; cyc++) begin
      @(negedge clk);
      if (bus.grant_o != '0 && prev == '0) begin got_order[ngr] = bus.grant_o; ngr++; end
      prev = bus.grant_o;
      for (int i = 0; i < N; i++) begin
        if (bus.ack_o[i]) bus.req_i[i] = 1'b0;
        else if (!bus.req_i[i] && !bus.grant_o[i]) begin bus.req_i[i] = 1'b1; set_msg(i, rnd_msg()); end
      end
    end
    n_tests++; if (ngr !== 4) begin n_fail++; $display("FAIL rr_timeout: got %0d grants exp 4", ngr); end
    for (int j = 0; j < ngr; j++) begin
      n_tests++; if (got_order[j] !== exp_order[j]) begin n_fail++; $display("FAIL rr_order[%0d]: got %b exp %b", j, got_order[j], exp_order[j]); end
    end
    n_tests++; if (bus.delivered_cnt_o !== 32'd3) begin n_fail++; $display("FAIL rr_cnt: got %0d exp 3", bus.delivered_cnt_o); end
  endtask

  task automatic test_starvation();
    bit found;
    apply_reset();
    set_msg(0, rnd_msg()); set_msg(2, rnd_msg());
    bus.req_i = 3'b001; bus.sink_ready_i = 1'b0;
    @(negedge clk);
    bus.req_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.starve_o !== 3'b000) begin n_fail++; $display("FAIL starve_early: got %b exp 000", bus.starve_o); end
    @(negedge clk);
    n_tests++; if (bus.starve_o !== 3'b100) begin n_fail++; $display("FAIL starve_set: got %b exp 100", bus.starve_o); end
    repeat (6) @(negedge clk);
    n_tests++; if (bus.starve_o !== 3'b100) begin n_fail++; $display("FAIL starve_saturate: got %b exp 100", bus.starve_o); end
    bus.sink_ready_i = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      if (bus.ack_o[0]) bus.req_i[0] = 1'b0;
      if (bus.grant_o == 3'b100) found = 1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL starve_grant_timeout: got %b exp 100", bus.grant_o); end
    @(negedge clk);
    n_tests++; if (bus.starve_o !== 3'b000) begin n_fail++; $display("FAIL starve_clear: got %b exp 000", bus.starve_o); end
    n_tests++; if (bus.ack_o !== 3'b100) begin n_fail++; $display("FAIL starve_ack: got %b exp 100", bus.ack_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic test_proto_err();
    apply_reset();
    for (int i = 0; i < N; i++) set_msg(i, rnd_msg());
    bus.req_i = 3'b001; bus.sink_ready_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b001 || bus.proto_err_o !== 1'b0) begin n_fail++; $display("FAIL perr_pre: got grant %b perr %b exp 001 0", bus.grant_o, bus.proto_err_o); end
    bus.req_i = 3'b000;
    @(negedge clk);
    n_tests++; if (bus.proto_err_o !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b exp 1", bus.proto_err_o); end
    n_tests++; if (bus.grant_o !== 3'b000 || bus.msg_valid_o !== 1'b0) begin n_fail++; $display("FAIL perr_idle: got grant %b valid %b exp 000 0", bus.grant_o, bus.msg_valid_o); end
    n_tests++; if (bus.ack_o !== 3'b000 || bus.delivered_cnt_o !== 32'd0) begin n_fail++; $display("FAIL perr_noack: got ack %b cnt %0d exp 000 0", bus.ack_o, bus.delivered_cnt_o); end
    bus.req_i = 3'b011; bus.sink_ready_i = 1'b1;  // pointer must still be at VN0
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b001) begin n_fail++; $display("FAIL perr_rr_kept: got %b exp 001", bus.grant_o); end
    @(negedge clk);
    n_tests++; if (bus.ack_o !== 3'b001 || bus.delivered_cnt_o !== 32'd1) begin n_fail++; $display("FAIL perr_after: got ack %b cnt %0d exp 001 1", bus.ack_o, bus.delivered_cnt_o); end
    n_tests++; if (bus.proto_err_o !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b exp 1", bus.proto_err_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    for (int i = 0; i < N; i++) set_msg(i, rnd_msg());
    bus.req_i = 3'b001; bus.sink_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);         // VN0 delivered, pointer now 1
    bus.req_i = 3'b000; bus.sink_ready_i = 1'b0;
    @(negedge clk); @(negedge clk);         // back to idle
    bus.req_i = 3'b010;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b010) begin n_fail++; $display("FAIL rmg_pre: got %b exp 010", bus.grant_o); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== '0 || bus.msg_valid_o !== 1'b0 || bus.msg_o !== '0) begin n_fail++; $display("FAIL rmg_out: got grant %b valid %b msg %h exp 0", bus.grant_o, bus.msg_valid_o, bus.msg_o); end
    n_tests++; if (bus.delivered_cnt_o !== 32'd0 || bus.ack_o !== '0) begin n_fail++; $display("FAIL rmg_cnt: got cnt %0d ack %b exp 0", bus.delivered_cnt_o, bus.ack_o); end
    rst = 1'b0; bus.req_i = 3'b011;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b001) begin n_fail++; $display("FAIL rmg_rr_reset: got %b exp 001", bus.grant_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.req_i = 3'b100; bus.sink_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.grant_o !== 3'b100 || bus.ack_o !== 3'b000) begin n_fail++; $display("FAIL rmg_vn2: got grant %b ack %b exp 100 000", bus.grant_o, bus.ack_o); end
    bus.req_i = '0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic test_random();
    int hold [N];
    bit acked [N];
    logic [N-1:0] exp_starve;
    logic [MW-1:0] exp_msg;
    bit exp_valid;
    apply_reset();
    for (int i = 0; i < N; i++) begin hold[i] = 0; acked[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      // VN agents and sink: stimulus only, reacting to observed ack/grant
      for (int i = 0; i < N; i++) begin
        if (bus.ack_o[i]) begin acked[i] = 1; hold[i] = $urandom_range(0, 2); end
        if (bus.req_i[i]) begin
          if (acked[i]) begin
            if (hold[i] == 0) begin bus.req_i[i] = 1'b0; acked[i] = 0; end
            else hold[i]--;
          end else if (bus.grant_o[i] && bus.msg_valid_o && $urandom_range(0, 39) == 0) begin
            bus.req_i[i] = 1'b0;
          end
        end else if (!bus.grant_o[i] && $urandom_range(0, 2) == 0) begin
          bus.req_i[i] = 1'b1; set_msg(i, rnd_msg());
        end
      end
      bus.sink_ready_i = ($urandom_range(0, 2) != 0);
      if (cyc == 400) begin rst = 1'b1; model_reset(); end
      else begin rst = 1'b0; model_step(); end
      @(negedge clk);
      exp_valid = (m_grant != '0) && !m_done;
      exp_msg   = exp_valid ? slot(owner(m_grant)) : '0;
      for (int i = 0; i < N; i++) exp_starve[i] = (m_wait[i] >= SL);
      n_tests++; if (bus.grant_o !== m_grant) begin n_fail++; $display("FAIL rnd_grant cyc %0d: got %b exp %b", cyc, bus.grant_o, m_grant); end
      n_tests++; if (bus.ack_o !== m_ack) begin n_fail++; $display("FAIL rnd_ack cyc %0d: got %b exp %b", cyc, bus.ack_o, m_ack); end
      n_tests++; if (bus.msg_valid_o !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b exp %b", cyc, bus.msg_valid_o, exp_valid); end
      n_tests++; if (bus.msg_o !== exp_msg) begin n_fail++; $display("FAIL rnd_msg cyc %0d: got %h exp %h", cyc, bus.msg_o, exp_msg); end
      n_tests++; if (bus.delivered_cnt_o !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d exp %0d", cyc, bus.delivered_cnt_o, m_cnt); end
      n_tests++; if (bus.proto_err_o !== m_perr) begin n_fail++; $display("FAIL rnd_perr cyc %0d: got %b exp %b", cyc, bus.proto_err_o, m_perr); end
      n_tests++; if (bus.starve_o !== exp_starve) begin n_fail++; $display("FAIL rnd_starve cyc %0d: got %b exp %b", cyc, bus.starve_o, exp_starve); end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req_i = '0; bus.msg_i = '0; bus.sink_ready_i = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_starvation();
    test_proto_err();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
